// File: rtl/cmd_fifo_param_if.sv
// Command FIFO bus interface.
// Groups the producer/consumer handshake, read data and status signals of
// cmd_fifo_param. The master side drives requests and consumes status.
// The slave side is the FIFO itself.
interface cmd_fifo_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 4
);
  // Requests from the producer/consumer side
  logic                  write;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read;
  logic                  clear_errors;

  // Read data and status returned by the FIFO
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write, data_in, read, clear_errors,
    input  data_out, data_valid, empty, full, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  write, data_in, read, clear_errors,
    output data_out, data_valid, empty, full, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/cmd_fifo_param.sv
// Parametrised synchronous command FIFO feeding the VGA drawing engine.
// Supports standard (registered, 1-cycle latency) and first-word-fall-through
// read modes. It has programmable almost-full/almost-empty thresholds, an
// occupancy level output, and sticky overflow/underflow flags.
// All DEPTH entries are usable because occupancy is tracked with an explicit
// level counter rather than derived from the pointers alone.
module cmd_fifo_param #(
  parameter int DATA_WIDTH         = 32,
  parameter int DEPTH_LOG2         = 4,
  parameter int FWFT               = 0,
  parameter int ALMOST_FULL_LEVEL  = 12,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset,
  cmd_fifo_param_if.slave   bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [LW-1:0]         lvl_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam lvl_t DEPTH_LVL = lvl_t'(DEPTH);
  localparam lvl_t AF_LVL    = lvl_t'(ALMOST_FULL_LEVEL);
  localparam lvl_t AE_LVL    = lvl_t'(ALMOST_EMPTY_LEVEL);
  localparam bit   FWFT_MODE = (FWFT == 1);

  // Illegal configurations stop elaboration.
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("cmd_fifo_param: DATA_WIDTH must be >= 1");
  end
  if (DEPTH_LOG2 < 1) begin : g_bad_depth
    $error("cmd_fifo_param: DEPTH_LOG2 must be >= 1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("cmd_fifo_param: FWFT must be 0 or 1");
  end
  if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
    $error("cmd_fifo_param: ALMOST_FULL_LEVEL must be in 1..DEPTH");
  end
  if (ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("cmd_fifo_param: ALMOST_EMPTY_LEVEL must be in 0..DEPTH-1");
  end

  // Storage; deliberately not reset so it can map onto plain RAM.
  word_t mem [DEPTH];

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  lvl_t  level_q, level_d;
  word_t data_out_q, data_out_d;
  logic  data_valid_q, data_valid_d;
  logic  overflow_q, overflow_d;
  logic  underflow_q, underflow_d;

  logic  empty_w;
  logic  full_w;
  logic  read_ok;
  logic  wr_ok;

  // Status flags come straight from the registered level.
  assign empty_w = (level_q == '0);
  assign full_w  = (level_q == DEPTH_LVL);

  // In FWFT mode a read acknowledges the word already on display.
  // In standard mode a read pulls the head word out.
  // A write into a full FIFO is still accepted when a read frees a slot in
  // the same cycle. An empty FIFO never forwards a write to a same-cycle read.
  assign read_ok = bus.read && (FWFT_MODE ? data_valid_q : !empty_w);
  assign wr_ok   = bus.write && (!full_w || read_ok);

  // Next-state for pointers, occupancy, read data and sticky error flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (read_ok) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    if (wr_ok && !read_ok) begin
      level_d = level_q + lvl_t'(1);
    end else if (read_ok && !wr_ok) begin
      level_d = level_q - lvl_t'(1);
    end

    if (FWFT_MODE) begin
      // Keep the post-update head on data_out. When the new head is the slot
      // being written this edge, the RAM does not hold it yet. This happens
      // when writing into an empty FIFO, or on a write+read at level 1.
      // In that case take the word from data_in.
      // When the FIFO drains, the last popped word stays visible.
      data_valid_d = (level_d != '0);
      if (level_d != '0) begin
        if (wr_ok && (wr_ptr_q == rd_ptr_d)) begin
          data_out_d = bus.data_in;
        end else begin
          data_out_d = mem[rd_ptr_d];
        end
      end
    end else begin
      // The read word lands one cycle after the request. It is flagged
      // valid for exactly that cycle and otherwise holds.
      data_valid_d = read_ok;
      if (read_ok) begin
        data_out_d = mem[rd_ptr_q];
      end
    end

    // A clear and a new error in the same cycle leave the flag set.
    if (bus.clear_errors) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.write && !wr_ok) begin
      overflow_d = 1'b1;
    end
    if (bus.read && !read_ok) begin
      underflow_d = 1'b1;
    end
  end

  // Control and output registers; reset discards all stored entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // RAM write port; a reset cycle must not store the word on data_in.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_full  = (level_q >= AF_LVL);
  assign bus.almost_empty = (level_q <= AE_LVL);
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_cmd_fifo_param.sv
// Self-checking bench for cmd_fifo_param.
// A standard-mode instance runs a vector table. The table gives hand-derived
// level and error-flag expectations. A queue model feeds a scoreboard of the
// words each accepted read must return. An FWFT instance runs hand-written
// multi-cycle sequences. A final mid-stream reset sequence checks that reset
// discards stored entries.
module tb_cmd_fifo_param;

  localparam int DW    = 32;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd;
    logic        clr;
    int          exp_level;
    logic        exp_ovf;
    logic        exp_udf;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  vec_t        vecs[$];
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cmd_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) if_std ();
  cmd_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) if_fw ();

  cmd_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .FWFT(0),
    .ALMOST_FULL_LEVEL(12), .ALMOST_EMPTY_LEVEL(2)
  ) u_std (
    .clk(clk), .reset(reset), .bus(if_std)
  );

  cmd_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .FWFT(1),
    .ALMOST_FULL_LEVEL(12), .ALMOST_EMPTY_LEVEL(2)
  ) u_fw (
    .clk(clk), .reset(reset), .bus(if_fw)
  );

  function automatic vec_t mk(input logic wr, input logic [31:0] din,
                              input logic rd, input logic clr,
                              input int lvl, input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.clr = clr;
    v.exp_level = lvl; v.exp_ovf = ovf; v.exp_udf = udf;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_std.write = 1'b0; if_std.data_in = '0; if_std.read = 1'b0; if_std.clear_errors = 1'b0;
    if_fw.write  = 1'b0; if_fw.data_in  = '0; if_fw.read  = 1'b0; if_fw.clear_errors  = 1'b0;
  endtask

  task automatic check_status_std(input string tag, input int lvl);
    check_output({tag, " level"}, 32'(if_std.level), 32'(lvl));
    check_output({tag, " empty"}, 32'(if_std.empty), 32'(lvl == 0));
    check_output({tag, " full"}, 32'(if_std.full), 32'(lvl == DEPTH));
    check_output({tag, " almost_full"}, 32'(if_std.almost_full), 32'(lvl >= 12));
    check_output({tag, " almost_empty"}, 32'(if_std.almost_empty), 32'(lvl <= 2));
  endtask

  // One cycle of the standard instance, scoreboarded against the queue model.
  task automatic apply_stimulus(input vec_t v, input int idx);
    bit    rok;
    bit    wok;
    string tag;
    tag = $sformatf("std[%0d]", idx);
    rok = v.rd && (model_q.size() != 0);
    wok = v.wr && ((model_q.size() < DEPTH) || rok);
    if (rok) exp_q.push_back(model_q.pop_front());
    if (wok) model_q.push_back(v.din);
    if_std.write = v.wr; if_std.data_in = v.din;
    if_std.read = v.rd; if_std.clear_errors = v.clr;
    @(posedge clk);
    #1;
    idle_inputs();
    check_status_std(tag, v.exp_level);
    check_output({tag, " overflow"}, 32'(if_std.overflow), 32'(v.exp_ovf));
    check_output({tag, " underflow"}, 32'(if_std.underflow), 32'(v.exp_udf));
    check_output({tag, " data_valid"}, 32'(if_std.data_valid), 32'(rok));
    if (if_std.data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output({tag, " unexpected data_out"}, if_std.data_out, 32'hxxxx_xxxx);
      end else begin
        check_output({tag, " data_out"}, if_std.data_out, exp_q.pop_front());
      end
    end
  endtask

  // One cycle of the FWFT instance followed by explicit expectations.
  task automatic fw_step(input string tag, input logic wr, input logic [31:0] din,
                         input logic rd, input logic clr, input logic exp_valid,
                         input logic [31:0] exp_data, input int lvl,
                         input logic ovf, input logic udf);
    if_fw.write = wr; if_fw.data_in = din; if_fw.read = rd; if_fw.clear_errors = clr;
    @(posedge clk);
    #1;
    idle_inputs();
    check_output({tag, " level"}, 32'(if_fw.level), 32'(lvl));
    check_output({tag, " data_valid"}, 32'(if_fw.data_valid), 32'(exp_valid));
    check_output({tag, " data_out"}, if_fw.data_out, exp_data);
    check_output({tag, " full"}, 32'(if_fw.full), 32'(lvl == DEPTH));
    check_output({tag, " overflow"}, 32'(if_fw.overflow), 32'(ovf));
    check_output({tag, " underflow"}, 32'(if_fw.underflow), 32'(udf));
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state of both instances
    check_status_std("reset", 0);
    check_output("reset std data_valid", 32'(if_std.data_valid), 32'd0);
    check_output("reset std data_out", if_std.data_out, 32'd0);
    check_output("reset std overflow", 32'(if_std.overflow), 32'd0);
    check_output("reset std underflow", 32'(if_std.underflow), 32'd0);
    check_output("reset fw data_valid", 32'(if_fw.data_valid), 32'd0);
    check_output("reset fw level", 32'(if_fw.level), 32'd0);

    // Standard-mode vector table
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1'b1, 32'h11 + 32'(i), 1'b0, 1'b0, i + 1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'hDEAD, 1'b0, 1'b0, 16, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 16, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'hAAAA, 1'b1, 1'b0, 16, 1'b0, 1'b0));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 15 - i, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h55, 1'b1, 1'b0, 1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0));
    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);
    check_output("std scoreboard drained", 32'(exp_q.size()), 32'd0);

    // FWFT: fall-through, no-bubble pop, drain hold, underflow and forwarding
    fw_step("fw wr77",      1'b1, 32'h77,  1'b0, 1'b0, 1'b1, 32'h77, 1, 1'b0, 1'b0);
    fw_step("fw wr88",      1'b1, 32'h88,  1'b0, 1'b0, 1'b1, 32'h77, 2, 1'b0, 1'b0);
    fw_step("fw rd1",       1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h88, 1, 1'b0, 1'b0);
    fw_step("fw rd2",       1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h88, 0, 1'b0, 1'b0);
    fw_step("fw rd empty",  1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h88, 0, 1'b0, 1'b1);
    fw_step("fw clear",     1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h88, 0, 1'b0, 1'b0);
    fw_step("fw wr+rd mt",  1'b1, 32'h99,  1'b1, 1'b0, 1'b1, 32'h99, 1, 1'b0, 1'b1);
    fw_step("fw wr+rd l1",  1'b1, 32'hA0,  1'b1, 1'b0, 1'b1, 32'hA0, 1, 1'b0, 1'b1);
    fw_step("fw clear2",    1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'hA0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      fw_step($sformatf("fw fill%0d", i), 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0,
              1'b1, 32'hA0, i + 2, 1'b0, 1'b0);
    end
    fw_step("fw wr full",   1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b1, 32'hA0,  16, 1'b1, 1'b0);
    fw_step("fw wr+rd ful", 1'b1, 32'hCAFE, 1'b1, 1'b0, 1'b1, 32'h100, 16, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      fw_step($sformatf("fw drain%0d", i), 1'b0, 32'h0, 1'b1, 1'b0, 1'b1,
              (i < 15) ? 32'h100 + 32'(i) : 32'hCAFE, 16 - i, 1'b1, 1'b0);
    end
    fw_step("fw last pop",  1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'hCAFE, 0, 1'b1, 1'b0);

    // Mid-stream reset on the standard instance with flags set and level 9
    vecs.delete();
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 1'b1));
    for (int i = 0; i < 9; i++) vecs.push_back(mk(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, i + 1, 1'b0, 1'b1));
    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], 100 + i);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_q.delete();
    check_status_std("midreset", 0);
    check_output("midreset data_valid", 32'(if_std.data_valid), 32'd0);
    check_output("midreset overflow", 32'(if_std.overflow), 32'd0);
    check_output("midreset underflow", 32'(if_std.underflow), 32'd0);
    check_output("midreset fw overflow", 32'(if_fw.overflow), 32'd0);
    apply_stimulus(mk(1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 1'b1), 200);
    check_output("final scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_fifo_param.md
Name: cmd_fifo_param

Overview:
- Parametrised synchronous command FIFO; next generation of the display engine's command queue.
- Sits between the command producer (host/bus decoder) and the VGA drawing engine.
- Adds configurable width and depth, a selectable first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty thresholds, an occupancy level output, and sticky overflow/underflow error flags.
- Uses the true DEPTH-entry capacity.

Parameters:
- DATA_WIDTH, 32, command word width in bits.
- DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (default 16); legal range >= 1.
- FWFT, 0, 0 = standard read (data after read), 1 = head word presented before read.
- ALMOST_FULL_LEVEL, 12, almost_full asserted when level >= this; legal 1..DEPTH.
- ALMOST_EMPTY_LEVEL, 2, almost_empty asserted when level <= this; legal 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- write  in  1  write request.
- data_in  in  DATA_WIDTH  word to store.
- read  in  1  read request (standard) / head acknowledge (FWFT).
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  data_out holds a valid word (see Behaviour).
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  level <= ALMOST_EMPTY_LEVEL.
- level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- clear_errors  in  1  clears sticky error flags.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was refused.

Behaviour:
- Reset (sampled on rising clk):
  - read/write pointers, level, data_out, data_valid, overflow and underflow all go to 0.
  - Consequently empty=1, almost_empty=1, full=0, almost_full=0.
  - RAM contents are not reset.
  - Reset overrides every other input in that cycle; asserting it mid-stream discards all stored entries.
- Acceptance, evaluated on the pre-edge state:
  - wr_ok = write && (!full || read_ok).
  - read_ok = read && !empty (FWFT: read && data_valid).
- Level update:
  - wr_ok && !read_ok: +1.
  - read_ok && !wr_ok: -1.
  - both or neither: unchanged.
  - Never leaves 0..DEPTH.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH (15 -> 0 at default).
- Full with write and read in the same cycle: both accepted, level stays DEPTH, no overflow.
- Empty with write and read in the same cycle: the write is accepted and the read is refused (underflow set). There is no same-cycle pass-through.
- Write when full without read: word dropped, RAM/pointers/level unchanged, overflow <= 1.
- Read when empty (FWFT: when !data_valid): no state change, data_out holds its value, underflow <= 1.
- Standard mode (FWFT=0):
  - On read_ok, data_out <= RAM[rd_ptr] at that edge; data_valid is 1 for exactly that one following cycle, else 0.
  - Read latency 1 cycle.
  - data_out holds its last value when not reading.
- FWFT mode (FWFT=1):
  - data_valid = 1 iff level != 0 (registered with level); data_out shows the head entry whenever data_valid=1.
  - A write into an empty FIFO appears on data_out with data_valid=1 on the cycle after the write edge.
  - read_ok pops the head; the next entry (if any) is on data_out the following cycle with no bubble.
  - When the FIFO drains, data_valid=0 and data_out holds the last popped word.
- Status outputs (empty, full, almost_*) derive from the registered level, so all update in the same cycle as level.
- Error flags:
  - Set by events as above.
  - Cleared by clear_errors=1 at the edge.
  - If a new error event and clear_errors coincide, the flag is set (set wins).
- Out-of-range parameters are a configuration error; the implementation must check them at elaboration and fail.

Test Plan:
- Defaults, FWFT=0: reset, write 0x11..0x1F then 0x20 (16 words) -> level=16, full=1, almost_full=1 from level 12. Then 16 reads -> data_out 0x11..0x20 in order, each 1 cycle after its read; empty=1 at end.
- Full + extra write 0xDEAD without read -> overflow=1, level stays 16, next reads return no 0xDEAD. Pulse clear_errors -> overflow=0.
- Full, write 0xAAAA with read same cycle -> level stays 16, overflow=0, 0xAAAA emerges as the 16th subsequent read. Pointers wrap correctly across 15->0.
- Empty, write 0x55 with read same cycle -> underflow=1, level=1, data_valid=0. The next read returns 0x55.
- FWFT=1: write 0x77 into empty -> next cycle data_valid=1, data_out=0x77 before any read. Write 0x88, read -> 0x88 shown the following cycle. Read again -> data_valid=0, level=0.
- Mid-stream reset with level=9 -> next cycle level=0, empty=1, data_valid=0, flags=0. A later read reports underflow.
